axis_rr_pkt_arbiter_256: RTL
============================

Name: axis_rr_pkt_arbiter_256

Overview:
Packet-granular round-robin arbiter. It shares one 256-bit AXI4-Stream path between up to 4 DMA source queues. It sits upstream of the 256-to-64 width converter, so that converter sees whole, non-interleaved packets. Once a port is granted, the arbiter holds that grant until the port's tlast beat completes. It also keeps per-port packet counters for status.

Parameters:
C_NUM_PORTS, 4, number of slave stream inputs (2..8)
C_AXIS_DATA_WIDTH, 256, tdata width of every stream
C_AXIS_TUSER_WIDTH, 128, tuser width of every stream
C_CNT_WIDTH, 16, width of each per-port packet counter

Ports:
axi_aclk  in  1  single clock; all logic is on its rising edge
axi_resetn  in  1  asynchronous, active-low reset
s_axis_tdata  in  N*256  flattened input data; port i occupies bits [i*256 +: 256]
s_axis_tstrb  in  N*32  flattened byte strobes
s_axis_tuser  in  N*128  flattened tuser
s_axis_tvalid  in  N  per-port valid
s_axis_tready  out  N  per-port ready
s_axis_tlast  in  N  per-port last
m_axis_tdata  out  256  muxed output data, to the converter
m_axis_tstrb  out  32  muxed strobes
m_axis_tuser  out  128  muxed tuser
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
port_en  in  N  per-port arbitration enable
grant  out  N  one-hot grant of the current packet; all zeros when no packet is granted
pkt_count  out  N*C_CNT_WIDTH  flattened per-port count of completed packets

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, grant = 0, last_grant = N-1 (so port 0 has first priority).
  - All pkt_count = 0.
  - Outputs while in reset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tstrb/tuser = 0, s_axis_tready = 0.
- A port i requests when s_axis_tvalid[i] && port_en[i] are both high.
- States:
  - IDLE:
    - m_axis_tvalid = 0; s_axis_tready = 0.
    - If any port requests, pick the first requester searching upward from last_grant+1, modulo N.
    - Register it into grant and last_grant; next state = PASS.
    - If no port requests, stay in IDLE.
  - PASS, with granted port g:
    - m_axis_* = s_axis_*[g], combinational passthrough.
    - s_axis_tready[g] = m_axis_tready; all other tready = 0.
    - On a beat where m_axis_tvalid && m_axis_tready && m_axis_tlast: increment pkt_count[g], clear grant, next state = IDLE.
- Latency:
  - One cycle from request to first data offered in PASS.
  - A fixed one-cycle IDLE bubble between consecutive packets, even when the same port requests again.
- Round-robin rules:
  - A port that just finished a packet has lowest priority at the next arbitration.
  - A single requester is granted every packet.
- port_en is sampled only in IDLE. Deasserting port_en[g] during PASS does not truncate the packet; the packet completes normally.
- tvalid may drop mid-packet on the granted port. The grant holds, no beat is produced, and other ports stay blocked.
- No state or grant changes while m_axis_tready = 0 (backpressure).
- Single-beat packets (tvalid && tlast on the first beat) take IDLE -> PASS -> IDLE.
- Counters wrap modulo 2^C_CNT_WIDTH.
- If a tvalid is asserted in the same cycle reset deasserts, the arbiter arbitrates on the first cycle after release.
- Reset mid-packet: the packet is abandoned (no flush logic). Downstream sees m_axis_tvalid drop. Recovery is the responsibility of the system reset.
- The output data mux is AND-OR on the one-hot grant, so no priority encoder sits on the data path.

Decomposition:
- The shared axis package holds:
  - state encoding localparams STATE_IDLE = 0, STATE_PASS = 1;
  - width constants 256/32/128;
  - function rr_next(req, last), returning a one-hot grant.
- One sub-module: rr_pick, combinational, with ports req[N], last_onehot[N] and grant_onehot[N]. It is reused by the future completion-queue arbiter.

Test Plan:
1. Reset, then all 4 ports request, each with a 2-beat packet; tready = 1 always -> packets exit in order port 0, 1, 2, 3. Each packet is 3 cycles (bubble + 2 beats). Final pkt_count = {1,1,1,1}.
2. Port 2 alone sends 3 single-beat packets -> grant = 4'b0100 three times, one-cycle bubble between packets, pkt_count[2] = 3.
3. Port 1 is granted a 4-beat packet; port_en[1] is cleared after beat 1 and port 3 requests -> all 4 beats of port 1 pass, then port 3 is granted. Port 1 is not re-granted while disabled.
4. Backpressure: m_axis_tready toggles 1,0,0,1 during a 3-beat packet -> output holds data and grant steady across the stalls, no beat is lost or duplicated, and s_axis_tready mirrors m_axis_tready.
5. axi_resetn is asserted asynchronously mid-packet on port 0 -> m_axis_tvalid = 0 immediately, and grant and counters read 0. After release, port 0 is top priority again.
6. Counter wrap with C_CNT_WIDTH = 4: port 3 sends 17 packets -> pkt_count[3] = 1.

Source files
------------

// File: rtl/axis_rr_pkt_arbiter_256_pkg.sv
// Shared constants, FSM state type and round-robin helper for the
// packet-granular AXI4-Stream arbiter.
package axis_rr_pkt_arbiter_256_pkg;

    localparam int unsigned C_AXIS_DW   = 256;
    localparam int unsigned C_AXIS_SW   = 32;
    localparam int unsigned C_AXIS_UW   = 128;
    localparam int unsigned C_MAX_PORTS = 8;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_PASS = 1'b1
    } state_e;

    // One-hot pick of the first requester strictly after 'last', modulo n.
    function automatic logic [C_MAX_PORTS-1:0] rr_next(
        input logic [C_MAX_PORTS-1:0] req,
        input logic [C_MAX_PORTS-1:0] last,
        input int unsigned            n
    );
        logic [C_MAX_PORTS-1:0] gnt;
        logic [C_MAX_PORTS-1:0] cand;
        int unsigned            last_idx;
        gnt      = '0;
        cand     = '0;
        last_idx = 0;
        for (int unsigned i = 0; i < C_MAX_PORTS; i++) begin
            if ((last & (C_MAX_PORTS'(1) << i)) != '0) last_idx = i;
        end
        for (int unsigned k = 1; k <= C_MAX_PORTS; k++) begin
            if (k <= n && gnt == '0) begin
                cand = C_MAX_PORTS'(1) << ((last_idx + k) % n);
                if ((req & cand) != '0) gnt = cand;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_256_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the next requester
// after the previous grant. Shared with the completion-queue arbiter.
module rr_pick
    import axis_rr_pkt_arbiter_256_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last_onehot,
    output logic [N-1:0] grant_onehot
);

    always_comb begin
        grant_onehot = N'(rr_next(C_MAX_PORTS'(req), C_MAX_PORTS'(last_onehot), N));
    end

endmodule

// File: rtl/axis_rr_pkt_arbiter_256.sv
// Packet-granular round-robin arbiter: N AXI4-Stream sources share one
// output path; a grant is held until the granted port's tlast beat completes.
module axis_rr_pkt_arbiter_256
    import axis_rr_pkt_arbiter_256_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS        = 4,
    parameter int unsigned C_AXIS_DATA_WIDTH  = C_AXIS_DW,
    parameter int unsigned C_AXIS_TUSER_WIDTH = C_AXIS_UW,
    parameter int unsigned C_CNT_WIDTH        = 16
) (
    input  logic                                                        axi_aclk,
    input  logic                                                        axi_resetn,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]                    s_axis_tdata,
    input  logic [C_NUM_PORTS*(C_AXIS_DATA_WIDTH/(C_AXIS_DW/C_AXIS_SW))-1:0] s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]                   s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                                      s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                                      s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                                      s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]                                m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/(C_AXIS_DW/C_AXIS_SW)-1:0]          m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                               m_axis_tuser,
    output logic                                                        m_axis_tvalid,
    input  logic                                                        m_axis_tready,
    output logic                                                        m_axis_tlast,
    input  logic [C_NUM_PORTS-1:0]                                      port_en,
    output logic [C_NUM_PORTS-1:0]                                      grant,
    output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]                          pkt_count
);

    localparam int unsigned N  = C_NUM_PORTS;
    localparam int unsigned DW = C_AXIS_DATA_WIDTH;
    localparam int unsigned SW = C_AXIS_DATA_WIDTH / (C_AXIS_DW / C_AXIS_SW);
    localparam int unsigned UW = C_AXIS_TUSER_WIDTH;
    localparam int unsigned CW = C_CNT_WIDTH;

    state_e           state_q;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     last_q;
    logic [N-1:0]     req;
    logic [N-1:0]     pick;
    logic             pkt_done;
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];

    assign req = s_axis_tvalid & port_en;

    rr_pick #(.N(N)) u_pick (
        .req          (req),
        .last_onehot  (last_q),
        .grant_onehot (pick)
    );

    // Reset value of last_q puts port N-1 last, so port 0 wins first.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q <= STATE_IDLE;
            grant_q <= '0;
            last_q  <= N'(1) << (N - 1);
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (|req) begin
                        grant_q <= pick;
                        last_q  <= pick;
                        state_q <= STATE_PASS;
                    end
                end
                STATE_PASS: begin
                    if (pkt_done) begin
                        grant_q <= '0;
                        state_q <= STATE_IDLE;
                    end
                end
                default: state_q <= STATE_IDLE;
            endcase
        end
    end

    // AND-OR mux on the one-hot grant; an all-zero grant yields all-zero outputs.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            m_axis_tdata  |= s_axis_tdata[i*DW +: DW] & {DW{grant_q[i]}};
            m_axis_tstrb  |= s_axis_tstrb[i*SW +: SW] & {SW{grant_q[i]}};
            m_axis_tuser  |= s_axis_tuser[i*UW +: UW] & {UW{grant_q[i]}};
            m_axis_tvalid |= s_axis_tvalid[i] & grant_q[i];
            m_axis_tlast  |= s_axis_tlast[i] & grant_q[i];
        end
    end

    assign s_axis_tready = grant_q & {N{m_axis_tready}};
    assign pkt_done      = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant         = grant_q;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = (pkt_done && grant_q[i]) ? cnt_q[i] + 1'b1 : cnt_q[i];
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int unsigned i = 0; i < N; i++) pkt_count[i*CW +: CW] = cnt_q[i];
    end

endmodule
